// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial stream, mode/clear controls and match statistics bundle
interface seq_detect_param_if #(
    parameter int CNT_W = 10
);
    logic             x;
    logic             x_valid;
    logic             overlap;
    logic             clr_count;
    logic             y;
    logic [CNT_W-1:0] users_count;
    logic             sat;

    modport master (
        output x, x_valid, overlap, clr_count,
        input  y, users_count, sat
    );

    modport slave (
        input  x, x_valid, overlap, clr_count,
        output y, users_count, sat
    );
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: detects PATTERN (MSB first) on a qualified serial stream,
// with overlap control and a saturating, clearable match counter.
module seq_detect_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b010,
    parameter int                 CNT_W   = 10
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int             FW      = $clog2(PAT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] hist, hist_nx;
    logic [FW-1:0]      fill, fill_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               match, y_q, sat_q, sat_nx;

    // fill proves hist holds PAT_LEN bits accepted since the last restart
    always_comb begin
        hist_nx = {hist[PAT_LEN-2:0], bus.x};
        match   = bus.x_valid && (hist_nx == PATTERN) && (fill >= FW'(PAT_LEN - 1));
        fill_nx = !bus.x_valid ? fill :
                  (match && !bus.overlap) ? '0 :
                  (fill == FW'(PAT_LEN)) ? fill : fill + FW'(1);
        cnt_nx  = bus.clr_count ? '0 :
                  (match && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;
        sat_nx  = !bus.clr_count && (sat_q || cnt_nx == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            cnt   <= '0;
            y_q   <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            if (bus.x_valid) hist <= hist_nx;
            fill  <= fill_nx;
            cnt   <= cnt_nx;
            y_q   <= match;
            sat_q <= sat_nx;
        end
    end

    assign bus.y           = y_q;
    assign bus.users_count = cnt;
    assign bus.sat         = sat_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: table vectors, corner sequences and a random stream
// checked against a queue-based model, on CNT_W=10 and CNT_W=4 instances.
module tb_seq_detect_param;
    localparam int          PL   = 3;
    localparam logic [2:0]  PAT  = 3'b010;
    localparam int          MAX10 = 1023;
    localparam int          MAX4  = 15;

    logic clk = 0;
    logic rst = 1;
    int   n_vec = 0;
    int   n_err = 0;

    seq_detect_param_if #(.CNT_W(10)) bus  ();
    seq_detect_param_if #(.CNT_W(4))  bus4 ();

    seq_detect_param #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(10)) dut  (.clk(clk), .rst(rst), .bus(bus));
    seq_detect_param #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // model: bits accepted since the last restart, newest at the back
    bit q[$];
    int c10, c4;
    bit s10, s4, ey;
    logic [PL-1:0] pat_v;

    typedef struct {
        bit r, x, v, ov, clr, ey;
        int ec;
    } vec_t;
    vec_t tab[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        c10 = 0; c4 = 0; s10 = 0; s4 = 0; ey = 0;
    endtask

    task automatic model_step(input bit xi, input bit vi, input bit ovi, input bit clri);
        ey = 0;
        if (vi) begin
            q.push_back(xi);
            if (q.size() > PL) void'(q.pop_front());
            if (q.size() == PL) begin
                ey = 1;
                for (int i = 0; i < PL; i++) if (q[i] != pat_v[PL-1-i]) ey = 0;
            end
            if (ey && !ovi) q.delete();
        end
        if (clri) begin
            c10 = 0; c4 = 0; s10 = 0; s4 = 0;
        end else if (ey) begin
            if (c10 < MAX10) c10++;
            if (c4 < MAX4) c4++;
            if (c10 == MAX10) s10 = 1;
            if (c4 == MAX4) s4 = 1;
        end
    endtask

    task automatic compare_all();
        check("y", bus.y, ey);
        check("cnt", bus.users_count, c10);
        check("sat", bus.sat, s10);
        check("y4", bus4.y, ey);
        check("cnt4", bus4.users_count, c4);
        check("sat4", bus4.sat, s4);
    endtask

    task automatic apply(input bit xi, input bit vi, input bit ovi, input bit clri);
        bus.x = xi;  bus.x_valid = vi;  bus.overlap = ovi;  bus.clr_count = clri;
        bus4.x = xi; bus4.x_valid = vi; bus4.overlap = ovi; bus4.clr_count = clri;
        @(posedge clk);
        model_step(xi, vi, ovi, clri);
        #1;
        compare_all();
    endtask

    // asserts reset mid-cycle and checks outputs clear without a clock edge
    task automatic async_reset();
        #3 rst = 0;
        model_reset();
        #1;
        check("rst_y", bus.y, 0);
        check("rst_cnt", bus.users_count, 0);
        check("rst_sat", bus.sat, 0);
        check("rst_cnt4", bus4.users_count, 0);
        check("rst_sat4", bus4.sat, 0);
        #2 rst = 1;
    endtask

    initial begin
        pat_v = PAT;
        bus.x = 0;  bus.x_valid = 0;  bus.overlap = 0;  bus.clr_count = 0;
        bus4.x = 0; bus4.x_valid = 0; bus4.overlap = 0; bus4.clr_count = 0;
        model_reset();
        async_reset();

        // {rst_before, x, x_valid, overlap, clr, exp_y, exp_cnt}
        tab = '{
            '{1,0,1,1,0,0,0}, '{0,1,1,1,0,0,0}, '{0,0,1,1,0,1,1}, '{0,1,1,1,0,0,1}, '{0,0,1,1,0,1,2},
            '{1,0,1,0,0,0,0}, '{0,1,1,0,0,0,0}, '{0,0,1,0,0,1,1}, '{0,1,1,0,0,0,1}, '{0,0,1,0,0,0,1},
            '{1,0,1,0,0,0,0}, '{0,1,0,0,0,0,0}, '{0,1,1,0,0,0,0}, '{0,1,0,0,0,0,0},
            '{0,0,0,0,0,0,0}, '{0,0,1,0,0,1,1}, '{0,1,0,0,0,0,1}
        };
        foreach (tab[i]) begin
            if (tab[i].r) async_reset();
            apply(tab[i].x, tab[i].v, tab[i].ov, tab[i].clr);
            check($sformatf("tab%0d_y", i), bus.y, tab[i].ey);
            check($sformatf("tab%0d_cnt", i), bus.users_count, tab[i].ec);
        end

        // five matches, then reset mid-cycle; a fresh "10" must not match
        async_reset();
        for (int i = 0; i < 11; i++) apply(i[0], 1, 1, 0);
        check("five_cnt", bus.users_count, 5);
        async_reset();
        apply(1, 1, 1, 0);
        check("post_rst_y1", bus.y, 0);
        apply(0, 1, 1, 0);
        check("post_rst_y2", bus.y, 0);
        check("post_rst_cnt", bus.users_count, 0);

        // saturation on the 4-bit counter
        async_reset();
        apply(0, 1, 1, 0);
        apply(1, 1, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) apply(1, 1, 1, 0);
            apply(0, 1, 1, 0);
            if (i == 14) check("sat4_early", bus4.sat, 0);
            if (i == 15) begin
                check("sat15_cnt4", bus4.users_count, 15);
                check("sat15_sat4", bus4.sat, 1);
            end
            if (i == 16) begin
                check("sat16_y4", bus4.y, 1);
                check("sat16_cnt4", bus4.users_count, 15);
                check("sat16_cnt10", bus.users_count, 16);
            end
        end
        apply(0, 0, 1, 1);
        check("clr_cnt4", bus4.users_count, 0);
        check("clr_sat4", bus4.sat, 0);

        // clear on the same edge as a match: clear wins, y still pulses
        apply(1, 1, 1, 0);
        apply(0, 1, 1, 1);
        check("coll_y", bus.y, 1);
        check("coll_cnt", bus.users_count, 0);
        check("coll_cnt4", bus4.users_count, 0);

        // random stream: non-overlap half then overlap half
        for (int i = 0; i < 9000; i++)
            apply(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8, i >= 4500,
                  $urandom_range(0, 499) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
